bram_resp: RTL and testbench
============================

BRAM_RESP -- requirements
Module: bram_resp

Interface
REQ-001 Parameter: DATA_SZ, default 16, data word width in bits.
REQ-002 Parameter: ADDR_SZ, default 8, address width in bits; storage is 2**ADDR_SZ words.
REQ-003 Port: i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_wr  input  1  write strobe; always accepted, no ready.
REQ-006 Port: i_waddr  input  ADDR_SZ  write address.
REQ-007 Port: i_wdata  input  DATA_SZ  write data.
REQ-008 Port: i_rd  input  1  read request valid.
REQ-009 Port: i_raddr  input  ADDR_SZ  read address.
REQ-010 Port: o_rd_ready  output  1  read request accepted when i_rd and o_rd_ready are both high at a clock edge.
REQ-011 Port: o_rvalid  output  1  response word available at FIFO head.
REQ-012 Port: o_rdata  output  DATA_SZ  response word; 0 when o_rvalid is low.
REQ-013 Port: i_rready  input  1  initiator consumes the head word when o_rvalid and i_rready are both high at a clock edge.

Function
REQ-014 Storage SHALL be a single 2**ADDR_SZ x DATA_SZ block RAM, initialized to all zeros at configuration.
REQ-015 When i_wr is high at an edge, mem[i_waddr] <= i_wdata.
REQ-016 An accepted read SHALL sample mem[i_raddr] at that edge into a one-stage in-flight register (inflight flag set).
REQ-017 Same-edge write and accepted read to the same address SHALL return the old (pre-write) contents: read-before-write.
REQ-018 On the edge after acceptance, the in-flight word SHALL be pushed into a 2-entry response FIFO.
REQ-019 Latency: read accepted at edge N with FIFO empty -> o_rvalid high and o_rdata valid in the cycle following edge N+1.
REQ-020 Responses SHALL be delivered in acceptance order; no word dropped or duplicated.
REQ-021 Occupancy = FIFO count + inflight, always <= 2.
REQ-022 o_rd_ready = (occupancy < 2) OR (o_rvalid AND i_rready); this combinational path from i_rready is permitted.
REQ-023 With i_rd and i_rready held high, sustained throughput SHALL be one read per clock.
REQ-024 Simultaneous push and pop in one edge SHALL leave the count unchanged and advance the head.
REQ-025 Pop with FIFO empty (i_rready high, o_rvalid low) SHALL have no effect.
REQ-026 FIFO read/write pointers SHALL be 1 bit each, wrapping modulo 2; count is 2 bits, range 0..2.
REQ-027 i_rd while o_rd_ready is low SHALL NOT be accepted; the initiator holds i_rd and i_raddr until accepted.
REQ-028 Writes SHALL never be stalled by read backpressure.

Reset
REQ-029 i_rst_n low SHALL immediately, without a clock, clear the FIFO pointers and count, clear inflight, drive o_rvalid = 0 and o_rdata = 0, and drive o_rd_ready = 1.
REQ-030 Reset mid-operation SHALL discard in-flight and queued responses.
REQ-031 Reset SHALL NOT alter memory contents.
REQ-032 While i_rst_n is low, i_wr and i_rd SHALL be ignored.
REQ-033 The first accepted read SHALL be possible at the first rising edge after i_rst_n deasserts.

Verification
REQ-034 Write FF=BE11, then 95=C0DE; read FF, then 95, with i_rready=1 -> o_rdata BE11, then C0DE, on consecutive cycles, each 2 edges after its acceptance.
REQ-035 Start with mem[FF]=C0DE; in one cycle write FF=FADE and read FF -> response C0DE; next read of FF -> FADE.
REQ-036 Hold i_rready=0; issue reads of FF, 95, FF -> first two accepted, o_rd_ready low while the third is pending. Raise i_rready -> third accepted; responses arrive in order FF, 95, FF.
REQ-037 Issue back-to-back reads of 00..07 with i_rready=1 -> o_rd_ready never low; 8 responses on 8 consecutive cycles.
REQ-038 Queue 2 responses (i_rready=0), then pulse i_rst_n low mid-cycle -> o_rvalid=0 and o_rdata=0 before the next edge. After release, read FF -> previously written value returned.

Source files
------------

// File: rtl/bram_resp.sv
// ============================================================================
// Module   : bram_resp
// Purpose  : Block-RAM with read-before-write port and 2-deep response FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_resp #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic               o_rd_ready,
  output logic               o_rvalid,
  output logic [DATA_SZ-1:0] o_rdata,
  input  logic               i_rready
);

  localparam int c_DEPTH = 2 ** ADDR_SZ;

  logic [DATA_SZ-1:0] mem_q [c_DEPTH];

  logic               inflight_q, inflight_d;
  logic [DATA_SZ-1:0] inflight_data_q;
  logic [DATA_SZ-1:0] fifo_q [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         count_q, count_d;

  logic               w_rd_accept;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_occupancy;

  // Occupancy counts the in-flight word too, so the FIFO can never overflow.
  assign w_occupancy = count_q + {1'b0, inflight_q};
  assign o_rvalid    = (count_q != 2'd0);
  assign o_rdata     = o_rvalid ? fifo_q[rptr_q] : '0;
  assign w_pop       = o_rvalid & i_rready;
  assign w_push      = inflight_q;
  assign o_rd_ready  = (w_occupancy < 2'd2) | w_pop;
  assign w_rd_accept = i_rst_n & i_rd & o_rd_ready;

  always_comb begin
    inflight_d = w_rd_accept;
    wptr_d     = wptr_q ^ w_push;
    rptr_d     = rptr_q ^ w_pop;
    count_d    = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Memory is deliberately outside reset; the read samples pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_wr) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rd_accept) begin
      inflight_data_q <= mem_q[i_raddr];
    end
    if (w_push) begin
      fifo_q[wptr_q] <= inflight_data_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_resp.sv
// ============================================================================
// Module   : tb_bram_resp
// Purpose  : Self-checking bench for bram_resp against a transaction-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bram_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wr = 1'b0;
  logic [7:0]  i_waddr = '0;
  logic [15:0] i_wdata = '0;
  logic        i_rd = 1'b0;
  logic [7:0]  i_raddr = '0;
  logic        i_rready = 1'b0;
  logic        o_rd_ready;
  logic        o_rvalid;
  logic [15:0] o_rdata;

  bram_resp #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr       (i_wr),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
    .i_rd       (i_rd),
    .i_raddr    (i_raddr),
    .o_rd_ready (o_rd_ready),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .i_rready   (i_rready)
  );

  always #5 clk = ~clk;

  // Model: every accepted read is an outstanding response; it becomes visible
  // once one further edge has passed after the edge that accepted it.
  typedef struct {
    logic [15:0] data;
    int          acc_edge;
  } resp_t;

  resp_t       q_m[$];
  logic [15:0] mem_m [256];
  int          edges = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic wr, input logic [7:0] wa, input logic [15:0] wd,
                      input logic rd, input logic [7:0] ra, input logic rr);
    logic        e_valid, e_ready, acc, pop;
    logic [15:0] e_data, rdv;
    resp_t       r;
    i_wr = wr; i_waddr = wa; i_wdata = wd;
    i_rd = rd; i_raddr = ra; i_rready = rr;
    @(negedge clk);
    e_valid = 1'b0;
    e_data  = 16'h0;
    if (rst_n && q_m.size() > 0) begin
      if (edges >= q_m[0].acc_edge + 1) begin
        e_valid = 1'b1;
        e_data  = q_m[0].data;
      end
    end
    e_ready = (q_m.size() < 2) || (e_valid && rr);
    chk("rd_ready", {31'b0, o_rd_ready}, {31'b0, e_ready});
    chk("rvalid",   {31'b0, o_rvalid},   {31'b0, e_valid});
    chk("rdata",    {16'b0, o_rdata},    {16'b0, e_data});
    acc = rst_n && rd && e_ready;
    pop = e_valid && rr;
    rdv = mem_m[ra];
    @(posedge clk);
    edges++;
    if (rst_n) begin
      if (pop) void'(q_m.pop_front());
      if (acc) begin
        r.data = rdv;
        r.acc_edge = edges;
        q_m.push_back(r);
      end
      if (wr) mem_m[wa] = wd;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 16'h0, 1'b0, 8'h00, rr);
  endtask

  initial begin
    logic        cur_rd;
    logic [7:0]  cur_ra;
    logic [7:0]  pool [4];
    pool[0] = 8'hFF; pool[1] = 8'h95; pool[2] = 8'h00; pool[3] = 8'h07;

    // Reset outputs are asserted without any clock edge.
    #2;
    chk("reset_rd_ready", {31'b0, o_rd_ready}, 32'd1);
    chk("reset_rvalid",   {31'b0, o_rvalid},   32'd0);
    chk("reset_rdata",    {16'b0, o_rdata},    32'd0);
    @(posedge clk); #1;
    step(1'b1, 8'h10, 16'hDEAD, 1'b1, 8'h10, 1'b1);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) step(1'b1, 8'(a), 16'h0000, 1'b0, 8'h00, 1'b1);

    // Two writes, then two back-to-back reads.
    step(1'b1, 8'hFF, 16'hBE11, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h95, 16'hC0DE, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h95, 1'b1);
    idle(3, 1'b1);

    // Same-edge write and read of one address returns the old word.
    step(1'b1, 8'hFF, 16'hC0DE, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 16'hFADE, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1);
    idle(3, 1'b1);

    // Backpressure: third read held until the consumer drains.
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h95, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b0);
    chk("third_held", {31'b0, o_rd_ready}, 32'd0);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1);
    idle(4, 1'b1);

    // Streaming reads at one per clock.
    for (int a = 0; a < 8; a++) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'(a), 1'b1);
    idle(3, 1'b1);

    // Queue two responses, then reset mid-cycle.
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h95, 1'b0);
    idle(1, 1'b0);
    chk("queued_valid", {31'b0, o_rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    q_m.delete();
    chk("midrst_rvalid",   {31'b0, o_rvalid},   32'd0);
    chk("midrst_rdata",    {16'b0, o_rdata},    32'd0);
    chk("midrst_rd_ready", {31'b0, o_rd_ready}, 32'd1);
    step(1'b1, 8'hFF, 16'h1234, 1'b1, 8'h95, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic over a small address pool to force collisions.
    cur_rd = 1'b0;
    cur_ra = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic        wr, rr;
      logic [7:0]  wa;
      logic [15:0] wd;
      if (!(cur_rd && !last_acc)) begin
        cur_rd = ($urandom_range(0, 3) != 0);
        cur_ra = pool[$urandom_range(0, 3)];
      end
      wr = $urandom_range(0, 1) == 1;
      wa = pool[$urandom_range(0, 3)];
      wd = 16'($urandom);
      rr = $urandom_range(0, 2) != 0;
      step(wr, wa, wd, cur_rd, cur_ra, rr);
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
